// File: rtl/shift_sequencer.sv
// Command sequencer for a downstream 4-bit universal shift register: one parallel
// load, then up to four serial shifts, then a one-cycle done pulse. Holds one pending command.
module shift_sequencer (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [3:0] data_in,
    input  logic       dir,
    input  logic [2:0] nshift,
    input  logic       fill,
    output logic       ready,
    output logic       s1,
    output logic       s0,
    output logic       enable,
    output logic [3:0] parallelin,
    output logic       serialinr,
    output logic       serialinl,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state_q,       state_d;
    logic [2:0] cnt_q,         cnt_d;
    logic [3:0] act_data_q,    act_data_d;
    logic       act_dir_q,     act_dir_d;
    logic [2:0] act_nshift_q,  act_nshift_d;
    logic       act_fill_q,    act_fill_d;
    logic       pend_valid_q,  pend_valid_d;
    logic [3:0] pend_data_q,   pend_data_d;
    logic       pend_dir_q,    pend_dir_d;
    logic [2:0] pend_nshift_q, pend_nshift_d;
    logic       pend_fill_q,   pend_fill_d;

    logic       accept;
    logic [2:0] nshift_sat;

    assign ready      = ~pend_valid_q;
    assign accept     = start & ~pend_valid_q;
    assign nshift_sat = (act_nshift_q > 3'd4) ? 3'd4 : act_nshift_q;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        cnt_d         = cnt_q;
        act_data_d    = act_data_q;
        act_dir_d     = act_dir_q;
        act_nshift_d  = act_nshift_q;
        act_fill_d    = act_fill_q;
        pend_valid_d  = pend_valid_q;
        pend_data_d   = pend_data_q;
        pend_dir_d    = pend_dir_q;
        pend_nshift_d = pend_nshift_q;
        pend_fill_d   = pend_fill_q;

        // A pending command always goes active before any new one, preserving order.
        if (((state_q == IDLE) || (state_q == DONE)) && pend_valid_q) begin
            act_data_d   = pend_data_q;
            act_dir_d    = pend_dir_q;
            act_nshift_d = pend_nshift_q;
            act_fill_d   = pend_fill_q;
            pend_valid_d = 1'b0;
            state_d      = LOAD;
        end else if ((state_q == IDLE) && accept) begin
            act_data_d   = data_in;
            act_dir_d    = dir;
            act_nshift_d = nshift;
            act_fill_d   = fill;
            state_d      = LOAD;
        end else if ((state_q != IDLE) && accept) begin
            pend_valid_d  = 1'b1;
            pend_data_d   = data_in;
            pend_dir_d    = dir;
            pend_nshift_d = nshift;
            pend_fill_d   = fill;
        end

        case (state_q)
            LOAD: begin
                cnt_d   = nshift_sat;
                state_d = (nshift_sat != 3'd0) ? SHIFT : DONE;
            end
            SHIFT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!pend_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            act_data_q    <= 4'd0;
            act_dir_q     <= 1'b0;
            act_nshift_q  <= 3'd0;
            act_fill_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_data_q   <= 4'd0;
            pend_dir_q    <= 1'b0;
            pend_nshift_q <= 3'd0;
            pend_fill_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            act_data_q    <= act_data_d;
            act_dir_q     <= act_dir_d;
            act_nshift_q  <= act_nshift_d;
            act_fill_q    <= act_fill_d;
            pend_valid_q  <= pend_valid_d;
            pend_data_q   <= pend_data_d;
            pend_dir_q    <= pend_dir_d;
            pend_nshift_q <= pend_nshift_d;
            pend_fill_q   <= pend_fill_d;
        end
    end

    // Outputs decode only flop contents, so none has a path from an input pin.
    always_comb begin
        s1         = 1'b0;
        s0         = 1'b0;
        enable     = 1'b0;
        done       = 1'b0;
        busy       = (state_q != IDLE);
        parallelin = (state_q != IDLE) ? act_data_q : 4'd0;
        serialinr  = (state_q != IDLE) & act_fill_q;
        serialinl  = (state_q != IDLE) & act_fill_q;
        case (state_q)
            LOAD: begin
                s1     = 1'b1;
                s0     = 1'b1;
                enable = 1'b1;
            end
            SHIFT: begin
                s1     = act_dir_q;
                s0     = ~act_dir_q;
                enable = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
